tile_dispatcher: RTL and testbench

//   Shares one host packet stream and one output write port between NUM_SOLVERS tile_solver_legit

---
 rtl/tile_dispatcher_pkg.sv | 10 +
 rtl/tile_dispatcher_rr_arbiter.sv | 32 +++
 rtl/tile_dispatcher.sv | 168 ++++++++++++++++
 tb/tb_tile_dispatcher.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_dispatcher_pkg.sv
// Shared types and helpers for the tile dispatcher and its arbiter.
package tile_dispatcher_pkg;

  typedef enum logic [1:0] {DISP_IDLE, DISP_ROUTE, DISP_GAP} disp_state_t;

  function automatic int pixels_per_tile(input int tw);
    return 1 << (2 * tw);
  endfunction

endpackage

// File: rtl/tile_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i, modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic [IW:0] idx;
  logic        found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_i} + (IW+1)'(k);
      if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
      if (en_i && !found && req_i[idx[IW-1:0]]) begin
        found                = 1'b1;
        gnt_o[idx[IW-1:0]]   = 1'b1;
        gnt_idx_o            = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/tile_dispatcher.sv
// Routes whole tile packets to the lowest free solver and merges solver pixel
// writes round-robin into one registered output stream; tracks busy and tile counts.
module tile_dispatcher
  import tile_dispatcher_pkg::*;
#(
  parameter int NUM_SOLVERS     = 4,
  parameter int SOLVER_IDX_BITS = 2,
  parameter int TILE_WIDTH_BITS = 5
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [31:0]                 in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_end_of_stream,
  output logic [31:0]                 sol_in_data,
  output logic [NUM_SOLVERS-1:0]      sol_in_valid,
  input  logic [NUM_SOLVERS-1:0]      sol_in_ready,
  output logic [NUM_SOLVERS-1:0]      sol_in_eos,
  input  logic [32*NUM_SOLVERS-1:0]   sol_out_addr,
  input  logic [16*NUM_SOLVERS-1:0]   sol_out_data,
  input  logic [NUM_SOLVERS-1:0]      sol_out_valid,
  output logic [NUM_SOLVERS-1:0]      sol_out_ready,
  output logic [31:0]                 out_addr,
  output logic [15:0]                 out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_SOLVERS-1:0]      busy,
  output logic [31:0]                 tiles_done
);

  localparam int            CW       = 2 * TILE_WIDTH_BITS + 1;
  localparam logic [CW-1:0] LAST_PIX = CW'(pixels_per_tile(TILE_WIDTH_BITS) - 1);

  disp_state_t                state_q;
  logic [SOLVER_IDX_BITS-1:0] sel_q;
  logic [SOLVER_IDX_BITS-1:0] free_idx;
  logic [NUM_SOLVERS-1:0]     busy_q, busy_d;
  logic [SOLVER_IDX_BITS-1:0] rr_ptr_q;
  logic [CW-1:0]              cnt_q [NUM_SOLVERS];
  logic [31:0]                tiles_done_q;
  logic                       out_valid_q;
  logic [31:0]                out_addr_q;
  logic [15:0]                out_data_q;

  logic                       load;
  logic [NUM_SOLVERS-1:0]     gnt;
  logic [SOLVER_IDX_BITS-1:0] gnt_idx;
  logic                       grant;
  logic                       tile_last;
  logic                       route_eos;
  logic [31:0]                g_addr;
  logic [15:0]                g_data;

  rr_arbiter #(
    .N  (NUM_SOLVERS),
    .IW (SOLVER_IDX_BITS)
  ) u_arb (
    .req_i     (sol_out_valid),
    .ptr_i     (rr_ptr_q),
    .en_i      (load),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign load          = ~out_valid_q | out_ready;
  assign grant         = |gnt;
  assign sol_out_ready = gnt;
  assign tile_last     = grant && busy_q[gnt_idx] && (cnt_q[gnt_idx] == LAST_PIX);

  // Host side is only connected through to the selected solver while routing.
  always_comb begin
    in_ready     = 1'b0;
    sol_in_data  = '0;
    sol_in_valid = '0;
    sol_in_eos   = '0;
    if (state_q == DISP_ROUTE) begin
      in_ready            = sol_in_ready[sel_q];
      sol_in_data         = in_data;
      sol_in_valid[sel_q] = in_valid;
      sol_in_eos[sel_q]   = in_end_of_stream;
    end
  end

  assign route_eos = (state_q == DISP_ROUTE) && in_valid && in_ready && in_end_of_stream;

  always_comb begin
    free_idx = '0;
    for (int i = NUM_SOLVERS - 1; i >= 0; i--)
      if (!busy_q[i]) free_idx = SOLVER_IDX_BITS'(i);
  end

  // Set and clear always target different solvers, so applying both is safe.
  always_comb begin
    busy_d = busy_q;
    if (tile_last) busy_d[gnt_idx] = 1'b0;
    if (route_eos) busy_d[sel_q]   = 1'b1;
  end

  always_comb begin
    g_addr = '0;
    g_data = '0;
    for (int i = 0; i < NUM_SOLVERS; i++) begin
      if (gnt[i]) begin
        g_addr = sol_out_addr[32*i +: 32];
        g_data = sol_out_data[16*i +: 16];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DISP_IDLE;
      sel_q   <= '0;
    end else begin
      case (state_q)
        DISP_IDLE: begin
          if (in_valid && !(&busy_q)) begin
            sel_q   <= free_idx;
            state_q <= DISP_ROUTE;
          end
        end
        DISP_ROUTE: if (route_eos) state_q <= DISP_GAP;
        DISP_GAP:   state_q <= DISP_IDLE;
        default:    state_q <= DISP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q       <= '0;
      rr_ptr_q     <= '0;
      tiles_done_q <= '0;
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      for (int i = 0; i < NUM_SOLVERS; i++) cnt_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      if (load) begin
        out_valid_q <= grant;
        if (grant) begin
          out_addr_q <= g_addr;
          out_data_q <= g_data;
          rr_ptr_q   <= (gnt_idx == SOLVER_IDX_BITS'(NUM_SOLVERS - 1)) ?
                        '0 : gnt_idx + SOLVER_IDX_BITS'(1);
          // Writes from a solver with no open tile pass through uncounted.
          if (busy_q[gnt_idx]) begin
            if (tile_last) begin
              cnt_q[gnt_idx] <= '0;
              tiles_done_q   <= tiles_done_q + 32'd1;
            end else begin
              cnt_q[gnt_idx] <= cnt_q[gnt_idx] + CW'(1);
            end
          end
        end
      end
    end
  end

  assign busy       = busy_q;
  assign tiles_done = tiles_done_q;
  assign out_valid  = out_valid_q;
  assign out_addr   = out_addr_q;
  assign out_data   = out_data_q;

endmodule

// File: tb/tb_tile_dispatcher.sv
// Directed bench for tile_dispatcher with behavioural solver models (4 solvers, 16-pixel tiles).
module tb_tile_dispatcher;

  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int TW  = 2;
  localparam int PPT = 16;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [31:0]       in_data;
  logic              in_valid;
  logic              in_ready;
  logic              in_end_of_stream;
  logic [31:0]       sol_in_data;
  logic [N-1:0]      sol_in_valid;
  logic [N-1:0]      sol_in_ready;
  logic [N-1:0]      sol_in_eos;
  logic [32*N-1:0]   sol_out_addr;
  logic [16*N-1:0]   sol_out_data;
  logic [N-1:0]      sol_out_valid;
  logic [N-1:0]      sol_out_ready;
  logic [31:0]       out_addr;
  logic [15:0]       out_data;
  logic              out_valid;
  logic              out_ready;
  logic [N-1:0]      busy;
  logic [31:0]       tiles_done;

  always #5 clock = ~clock;

  tile_dispatcher #(
    .NUM_SOLVERS     (N),
    .SOLVER_IDX_BITS (IW),
    .TILE_WIDTH_BITS (TW)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_end_of_stream (in_end_of_stream),
    .sol_in_data      (sol_in_data),
    .sol_in_valid     (sol_in_valid),
    .sol_in_ready     (sol_in_ready),
    .sol_in_eos       (sol_in_eos),
    .sol_out_addr     (sol_out_addr),
    .sol_out_data     (sol_out_data),
    .sol_out_valid    (sol_out_valid),
    .sol_out_ready    (sol_out_ready),
    .out_addr         (out_addr),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .busy             (busy),
    .tiles_done       (tiles_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Solver models: accept beats, then emit PPT writes per tile when enabled.
  logic [N-1:0] emit_mask;
  int           pend      [N];
  logic [15:0]  seq       [N];
  int           beats     [N];
  logic [31:0]  last_word [N];
  int           last_dest;

  assign sol_in_ready = '1;

  always_comb begin
    sol_out_valid = '0;
    sol_out_addr  = '0;
    sol_out_data  = '0;
    for (int i = 0; i < N; i++) begin
      sol_out_valid[i]        = emit_mask[i] && (pend[i] > 0);
      sol_out_addr[32*i +: 32] = {8'hF0, 4'h0, 4'(i), seq[i]};
      sol_out_data[16*i +: 16] = {4'(i), seq[i][11:0]};
    end
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        pend[i]      <= 0;
        seq[i]       <= '0;
        beats[i]     <= 0;
        last_word[i] <= '0;
      end
      last_dest <= -1;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sol_in_valid[i] && sol_in_ready[i]) begin
          beats[i]     <= beats[i] + 1;
          last_word[i] <= sol_in_data;
          if (sol_in_eos[i]) last_dest <= i;
        end
        pend[i] <= pend[i]
                   + ((sol_in_valid[i] && sol_in_ready[i] && sol_in_eos[i]) ? PPT : 0)
                   - ((sol_out_valid[i] && sol_out_ready[i]) ? 1 : 0);
        if (sol_out_valid[i] && sol_out_ready[i]) seq[i] <= seq[i] + 16'd1;
      end
    end
  end

  // Output scoreboard: per-solver in-order sequence, plus hold stability under backpressure.
  int          rcv [16];
  int          rcv_total;
  logic        hold_v;
  logic [31:0] hold_addr;
  logic [15:0] hold_data;
  logic [3:0]  mon_s;
  assign mon_s = out_data[15:12];

  always @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) rcv[i] <= 0;
      rcv_total <= 0;
      hold_v    <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
    end else begin
      if (hold_v) begin
        chk("hold_vld", out_valid, 1'b1);
        chk("hold_addr", out_addr, hold_addr);
        chk("hold_data", out_data, hold_data);
      end
      hold_v    <= out_valid && !out_ready;
      hold_addr <= out_addr;
      hold_data <= out_data;
      if (out_valid && out_ready) begin
        chk("wr_data", out_data, {mon_s, 12'(rcv[mon_s])});
        chk("wr_addr", out_addr, {8'hF0, 4'h0, mon_s, 16'(rcv[mon_s])});
        rcv[mon_s] <= rcv[mon_s] + 1;
        rcv_total  <= rcv_total + 1;
      end
    end
  end

  task automatic send_pkt(input int nb, input logic [31:0] base, input int max_wait);
    int w;
    for (int b = 0; b < nb; b++) begin
      in_valid         = 1'b1;
      in_data          = base + 32'(b);
      in_end_of_stream = (b == nb - 1);
      w = 0;
      @(negedge clock);
      while (!in_ready && w < max_wait) begin
        @(negedge clock);
        w++;
      end
      if (!in_ready) begin
        chk("pkt_timeout", 1'b0, 1'b1);
        in_valid         = 1'b0;
        in_end_of_stream = 1'b0;
        return;
      end
      @(posedge clock);
      #1;
    end
    in_valid         = 1'b0;
    in_end_of_stream = 1'b0;
  endtask

  int rdy_seen;
  int exp_g;
  int base_total;
  int w6;

  initial begin
    reset_n          = 1'b0;
    in_valid         = 1'b1;
    in_data          = 32'h2000_0001;
    in_end_of_stream = 1'b0;
    out_ready        = 1'b0;
    emit_mask        = '0;

    // Reset held with a beat presented
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("t1_in_ready", in_ready, 1'b0);
    chk("t1_out_valid", out_valid, 1'b0);
    chk("t1_busy", busy, 4'b0000);
    chk("t1_tiles", tiles_done, 32'd0);
    chk("t1_out_addr", out_addr, 32'd0);
    chk("t1_sol_in_valid", sol_in_valid, 4'b0000);
    in_valid = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Single 3-beat packet to solver 0, then the gap cycle
    send_pkt(3, 32'hA000_0001, 20);
    chk("t2_dest", 32'(last_dest), 32'd0);
    chk("t2_beats0", 32'(beats[0]), 32'd3);
    chk("t2_last_word", last_word[0], 32'hA000_0003);
    chk("t2_beats1", 32'(beats[1]), 32'd0);
    chk("t2_busy", busy, 4'b0001);
    in_valid = 1'b1;
    in_data  = 32'hBBBB_0000;
    @(negedge clock);
    chk("t2_gap_ready", in_ready, 1'b0);
    chk("t2_gap_valid", sol_in_valid, 4'b0000);
    @(posedge clock);
    #1 in_valid = 1'b0;

    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // Four packets fill the solvers in index order; the fifth waits for solver 2
    for (int p = 0; p < 4; p++) begin
      send_pkt(2, 32'hC000_0000 + 32'(p * 16), 20);
      chk("t3_dest", 32'(last_dest), 32'(p));
    end
    chk("t3_busy_full", busy, 4'b1111);
    in_valid         = 1'b1;
    in_data          = 32'hC000_0040;
    in_end_of_stream = 1'b0;
    rdy_seen = 0;
    repeat (6) begin
      @(negedge clock);
      if (in_ready || (sol_in_valid != '0)) rdy_seen++;
    end
    chk("t3_wait", 32'(rdy_seen), 32'd0);
    emit_mask = 4'b0100;
    out_ready = 1'b1;
    send_pkt(2, 32'hC000_0040, 100);
    emit_mask = '0;
    chk("t3_dest5", 32'(last_dest), 32'd2);
    chk("t3_busy5", busy, 4'b1111);
    chk("t3_tiles", tiles_done, 32'd1);
    repeat (3) @(posedge clock);
    #1;
    chk("t3_rcv2", 32'(rcv[2]), 32'd16);

    // All solvers requesting, out_ready high: rotation starts after solver 2
    emit_mask = 4'b1111;
    exp_g = 3;
    for (int k = 0; k < 64; k++) begin
      @(negedge clock);
      chk("t4_gnt", sol_out_ready, 4'b0001 << exp_g);
      exp_g = (exp_g + 1) % N;
    end
    repeat (3) @(posedge clock);
    #1;
    chk("t4_busy", busy, 4'b0000);
    chk("t4_tiles", tiles_done, 32'd5);
    chk("t4_rcv0", 32'(rcv[0]), 32'd16);
    chk("t4_rcv1", 32'(rcv[1]), 32'd16);
    chk("t4_rcv2", 32'(rcv[2]), 32'd32);
    chk("t4_rcv3", 32'(rcv[3]), 32'd16);

    // Same traffic with out_ready toggling every cycle
    emit_mask = '0;
    for (int p = 0; p < 4; p++) begin
      send_pkt(1, 32'hE000_0000 + 32'(p), 20);
      chk("t5_dest", 32'(last_dest), 32'(p));
    end
    base_total = rcv_total;
    emit_mask  = 4'b1111;
    for (int c = 0; c < 400 && (rcv_total - base_total) < 64; c++) begin
      @(posedge clock);
      #1 out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("t5_total", 32'(rcv_total - base_total), 32'd64);
    chk("t5_rcv0", 32'(rcv[0]), 32'd32);
    chk("t5_rcv2", 32'(rcv[2]), 32'd48);
    chk("t5_rcv3", 32'(rcv[3]), 32'd32);
    chk("t5_busy", busy, 4'b0000);
    chk("t5_tiles", tiles_done, 32'd9);

    // Asynchronous reset in the middle of a packet and a tile
    emit_mask = '0;
    send_pkt(2, 32'hF000_0000, 20);
    chk("t6_dest0", 32'(last_dest), 32'd0);
    in_valid         = 1'b1;
    in_data          = 32'hF100_0000;
    in_end_of_stream = 1'b0;
    w6 = 0;
    @(negedge clock);
    while (!in_ready && w6 < 10) begin
      @(negedge clock);
      w6++;
    end
    chk("t6_accept", in_ready, 1'b1);
    @(posedge clock);
    #1 in_data = 32'hF100_0001;
    emit_mask = 4'b0001;
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk("t6_pre_route", sol_in_valid, 4'b0010);
    chk("t6_pre_ov", out_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_in_ready", in_ready, 1'b0);
    chk("t6_sol_in_valid", sol_in_valid, 4'b0000);
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_out_addr", out_addr, 32'd0);
    chk("t6_out_data", out_data, 16'd0);
    chk("t6_busy", busy, 4'b0000);
    chk("t6_tiles", tiles_done, 32'd0);
    chk("t6_sol_out_ready", sol_out_ready, 4'b0000);
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    emit_mask = '0;
    reset_n   = 1'b1;
    send_pkt(3, 32'h1234_0000, 20);
    chk("t6_dest_after", 32'(last_dest), 32'd0);
    chk("t6_beats0", 32'(beats[0]), 32'd3);
    chk("t6_busy_after", busy, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
